// File: rtl/pipe_ctrl_unit.sv
// Pipeline control unit: ID decode, load-use / multi-cycle stall FSM and EX->MEM->WB control registers.
// Define CTRL_MEXT_EN to decode M-extension ops (funct7=0000001 on OP) as multi-cycle EX operations.
module pipe_ctrl_unit #(
    parameter int LOAD_BUBBLES  = 1,
    parameter int MULDIV_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_i,
    input  logic        instr_valid_i,
    input  logic        flush_i,
    output logic        STALLSIG,
    output logic        ex_ALUSRC,
    output logic        ex_IMMTOREG,
    output logic        ex_MULDIV,
    output logic [1:0]  ex_ALUOP,
    output logic [1:0]  ex_BRANCH,
    output logic        mem_MEMWRITE,
    output logic        mem_MEMREAD,
    output logic        wb_REGWRITE,
    output logic [1:0]  wb_REGWRITESEL,
    output logic [4:0]  ex_rd,
    output logic [4:0]  mem_rd,
    output logic [4:0]  wb_rd,
    output logic        illegal_o
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        MDBUSY = 2'd2
    } state_t;

    typedef struct packed {
        logic       alusrc;
        logic       immtoreg;
        logic       muldiv;
        logic [1:0] aluop;
        logic [1:0] branch;
        logic [1:0] wsel;
        logic       memwrite;
        logic       memread;
        logic       regwrite;
        logic [4:0] rd;
    } ex_ctrl_t;

    typedef struct packed {
        logic       memwrite;
        logic       memread;
        logic       regwrite;
        logic [1:0] wsel;
        logic [4:0] rd;
    } mem_ctrl_t;

    typedef struct packed {
        logic       regwrite;
        logic [1:0] wsel;
        logic [4:0] rd;
    } wb_ctrl_t;

`ifdef CTRL_MEXT_EN
    localparam logic MEXT_EN = 1'b1;
`else
    localparam logic MEXT_EN = 1'b0;
`endif

    localparam ex_ctrl_t   EX_BUBBLE = 17'b0_0_0_00_01_00_0_0_0_00000;
    localparam logic [5:0] LOAD_CNT  = 6'(LOAD_BUBBLES - 1);
    localparam logic [5:0] MD_CNT    = 6'(MULDIV_CYCLES - 1);

    // Field vector order: {ALUSRC, IMMTOREG, ALUOP, BRANCH, REGWRITESEL, MEMWRITE, MEMREAD, REGWRITE}.
    function automatic ex_ctrl_t fields_f(input logic [10:0] f);
        ex_ctrl_t c;
        c = EX_BUBBLE;
        {c.alusrc, c.immtoreg, c.aluop, c.branch, c.wsel, c.memwrite, c.memread, c.regwrite} = f;
        return c;
    endfunction

    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    ex_ctrl_t   ex_q, ex_d, dec_s;
    mem_ctrl_t  mem_q, mem_d;
    wb_ctrl_t   wb_q, wb_d;
    logic       illegal_q;
    logic       dec_illegal_s;
    logic       uses_rs2_s;
    logic       hazard_s;
    logic       stall_s;
    logic       mem_bubble_s;
    logic       unused_funct3_s;

    assign unused_funct3_s = ^instr_i[14:12];

    // Combinational ID-stage decode; anything not listed becomes a bubble.
    always_comb begin
        dec_s         = EX_BUBBLE;
        dec_illegal_s = 1'b0;
        if (instr_valid_i) begin
            case (instr_i[6:0])
                7'b0110011: begin
                    if (instr_i[31:25] == 7'b0000001) begin
                        if (MEXT_EN) begin
                            dec_s.muldiv   = 1'b1;
                            dec_s.aluop    = 2'b10;
                            dec_s.regwrite = 1'b1;
                        end else begin
                            dec_illegal_s = 1'b1;
                        end
                    end else begin
                        dec_s = fields_f(11'b0_0_10_01_00_0_0_1);
                    end
                end
                7'b0010011: dec_s = fields_f(11'b1_0_10_01_00_0_0_1);
                7'b0000011: dec_s = fields_f(11'b1_0_00_01_01_0_1_1);
                7'b1100111: dec_s = fields_f(11'b1_0_11_10_10_0_0_1);
                7'b0100011: dec_s = fields_f(11'b1_0_00_01_00_1_0_0);
                7'b1100011: dec_s = fields_f(11'b0_0_01_11_00_0_0_0);
                7'b0110111: dec_s = fields_f(11'b0_1_00_01_00_0_0_1);
                7'b0010111: dec_s = fields_f(11'b0_0_11_11_11_0_0_1);
                7'b1101111: dec_s = fields_f(11'b0_0_11_11_10_0_0_1);
                default:    dec_illegal_s = 1'b1;
            endcase
            // rd only matters for writers; S/B immediate bits must not look like a destination.
            if (dec_s.regwrite) begin
                dec_s.rd = instr_i[11:7];
            end else begin
                dec_s.rd = 5'd0;
            end
        end else begin
            dec_illegal_s = 1'b0;
        end
    end

    // Load-use detection against the load currently in EX.
    always_comb begin
        uses_rs2_s = (instr_i[6:0] == 7'b0110011) || (instr_i[6:0] == 7'b0100011) ||
                     (instr_i[6:0] == 7'b1100011);
        if (instr_valid_i && ex_q.memread && (ex_q.rd != 5'd0)) begin
            hazard_s = (ex_q.rd == instr_i[19:15]) || (uses_rs2_s && (ex_q.rd == instr_i[24:20]));
        end else begin
            hazard_s = 1'b0;
        end
    end

    // Stall FSM next-state, stall output and EX-stage next value.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        stall_s      = 1'b0;
        ex_d         = dec_s;
        mem_bubble_s = 1'b0;
        case (state_q)
            RUN: begin
                if (flush_i) begin
                    ex_d    = EX_BUBBLE;
                    state_d = RUN;
                    cnt_d   = 6'd0;
                end else if (hazard_s) begin
                    stall_s = 1'b1;
                    ex_d    = EX_BUBBLE;
                    if (LOAD_BUBBLES > 1) begin
                        state_d = LSTALL;
                        cnt_d   = LOAD_CNT;
                    end else begin
                        state_d = RUN;
                        cnt_d   = 6'd0;
                    end
                end else if (dec_s.muldiv) begin
                    state_d = MDBUSY;
                    cnt_d   = MD_CNT;
                end else begin
                    state_d = RUN;
                    cnt_d   = 6'd0;
                end
            end
            LSTALL: begin
                ex_d = EX_BUBBLE;
                if (flush_i) begin
                    state_d = RUN;
                    cnt_d   = 6'd0;
                end else begin
                    stall_s = 1'b1;
                    if (cnt_q <= 6'd1) begin
                        state_d = RUN;
                        cnt_d   = 6'd0;
                    end else begin
                        cnt_d = cnt_q - 6'd1;
                    end
                end
            end
            MDBUSY: begin
                // The M-op is older than any branch in EX's shadow, so flush is ignored here.
                stall_s      = 1'b1;
                ex_d         = ex_q;
                mem_bubble_s = 1'b1;
                if (cnt_q <= 6'd1) begin
                    state_d = RUN;
                    cnt_d   = 6'd0;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 6'd0;
                ex_d    = EX_BUBBLE;
            end
        endcase
    end

    // MEM and WB stage next values.
    always_comb begin
        if (mem_bubble_s) begin
            mem_d = '0;
        end else begin
            mem_d = '{memwrite: ex_q.memwrite, memread: ex_q.memread, regwrite: ex_q.regwrite,
                      wsel: ex_q.wsel, rd: ex_q.rd};
        end
        wb_d = '{regwrite: mem_q.regwrite, wsel: mem_q.wsel, rd: mem_q.rd};
    end

    // State, counter and stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            cnt_q     <= 6'd0;
            ex_q      <= EX_BUBBLE;
            mem_q     <= '0;
            wb_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ex_q      <= ex_d;
            mem_q     <= mem_d;
            wb_q      <= wb_d;
            illegal_q <= dec_illegal_s;
        end
    end

    assign STALLSIG       = stall_s;
    assign ex_ALUSRC      = ex_q.alusrc;
    assign ex_IMMTOREG    = ex_q.immtoreg;
    assign ex_MULDIV      = ex_q.muldiv & MEXT_EN;
    assign ex_ALUOP       = ex_q.aluop;
    assign ex_BRANCH      = ex_q.branch;
    assign ex_rd          = ex_q.rd;
    assign mem_MEMWRITE   = mem_q.memwrite;
    assign mem_MEMREAD    = mem_q.memread;
    assign mem_rd         = mem_q.rd;
    assign wb_REGWRITE    = wb_q.regwrite;
    assign wb_REGWRITESEL = wb_q.wsel;
    assign wb_rd          = wb_q.rd;
    assign illegal_o      = illegal_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: directed scenarios plus randomized traffic against a stage-slot model.
module tb_pipe_ctrl_unit;
    localparam int LB = 2;
    localparam int MC = 4;
`ifdef CTRL_MEXT_EN
    localparam bit MEXT = 1'b1;
`else
    localparam bit MEXT = 1'b0;
`endif

    localparam logic [31:0] ADD123 = 32'h003100B3;  // add x1,x2,x3
    localparam logic [31:0] LW5    = 32'h0000A283;  // lw  x5,0(x1)
    localparam logic [31:0] ADD652 = 32'h00228333;  // add x6,x5,x2
    localparam logic [31:0] LW0    = 32'h0000A003;  // lw  x0,0(x1)
    localparam logic [31:0] ADD602 = 32'h00200333;  // add x6,x0,x2
    localparam logic [31:0] MUL712 = 32'h022083B3;  // mul x7,x1,x2

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr_i = 32'd0;
    logic        instr_valid_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        STALLSIG, ex_ALUSRC, ex_IMMTOREG, ex_MULDIV;
    logic [1:0]  ex_ALUOP, ex_BRANCH;
    logic        mem_MEMWRITE, mem_MEMREAD, wb_REGWRITE;
    logic [1:0]  wb_REGWRITESEL;
    logic [4:0]  ex_rd, mem_rd, wb_rd;
    logic        illegal_o;

    int checks = 0;
    int errors = 0;
    int stall_seen = 0;
    int md_seen = 0;

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.LOAD_BUBBLES(LB), .MULDIV_CYCLES(MC)) dut (
        .clk(clk), .rst_n(rst_n), .instr_i(instr_i), .instr_valid_i(instr_valid_i), .flush_i(flush_i),
        .STALLSIG(STALLSIG), .ex_ALUSRC(ex_ALUSRC), .ex_IMMTOREG(ex_IMMTOREG), .ex_MULDIV(ex_MULDIV),
        .ex_ALUOP(ex_ALUOP), .ex_BRANCH(ex_BRANCH), .mem_MEMWRITE(mem_MEMWRITE), .mem_MEMREAD(mem_MEMREAD),
        .wb_REGWRITE(wb_REGWRITE), .wb_REGWRITESEL(wb_REGWRITESEL), .ex_rd(ex_rd), .mem_rd(mem_rd),
        .wb_rd(wb_rd), .illegal_o(illegal_o)
    );

    // One slot type per pipeline stage; later stages just ignore the EX-only fields.
    typedef struct packed {
        logic       alusrc, immtoreg, muldiv;
        logic [1:0] aluop, branch, wsel;
        logic       mw, mr, rw;
        logic [4:0] rd;
    } slot_t;

    logic [6:0]  opc_tab [9] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
    logic [10:0] fld_tab [9] = '{11'b0_0_10_01_00_0_0_1, 11'b1_0_10_01_00_0_0_1, 11'b1_0_00_01_01_0_1_1,
                                 11'b1_0_11_10_10_0_0_1, 11'b1_0_00_01_00_1_0_0, 11'b0_0_01_11_00_0_0_0,
                                 11'b0_1_00_01_00_0_0_1, 11'b0_0_11_11_11_0_0_1, 11'b0_0_11_11_10_0_0_1};
    logic [6:0]  rnd_ops [11] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F,
                                  7'h0F, 7'h7F};

    slot_t m_ex, m_mem, m_wb, n_ex, n_mem, n_wb;
    logic  m_ill = 1'b0, n_ill = 1'b0;
    int    m_ls = 0, m_md = 0, n_ls = 0, n_md = 0;

    function automatic slot_t bubble();
        slot_t s;
        s = '0;
        s.branch = 2'b01;
        return s;
    endfunction

    function automatic void mdecode(input logic [31:0] ins, input logic v, output slot_t s, output logic ill);
        logic found;
        s = bubble();
        ill = 1'b0;
        found = 1'b0;
        if (v) begin
            if (ins[6:0] == 7'h33 && ins[31:25] == 7'h01) begin
                if (MEXT) begin
                    s.muldiv = 1'b1;
                    s.aluop = 2'b10;
                    s.rw = 1'b1;
                    s.rd = ins[11:7];
                end else begin
                    ill = 1'b1;
                end
            end else begin
                for (int i = 0; i < 9; i++) begin
                    if (opc_tab[i] == ins[6:0]) begin
                        {s.alusrc, s.immtoreg, s.aluop, s.branch, s.wsel, s.mw, s.mr, s.rw} = fld_tab[i];
                        found = 1'b1;
                    end
                end
                ill = !found;
                if (s.rw) s.rd = ins[11:7];
            end
        end
    endfunction

    function automatic void model_reset();
        m_ex = bubble();
        m_mem = bubble();
        m_wb = bubble();
        m_ill = 1'b0;
        m_ls = 0;
        m_md = 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model register update; reset is asynchronous like the DUT's.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            m_ex = n_ex;
            m_mem = n_mem;
            m_wb = n_wb;
            m_ill = n_ill;
            m_ls = n_ls;
            m_md = n_md;
        end
    end

    // Compare DUT against the model, then work out the model's next stage contents.
    always @(negedge clk) begin : cmp
        slot_t d;
        logic  ill, hz, stall, rs2;
        mdecode(instr_i, instr_valid_i, d, ill);
        rs2 = (instr_i[6:0] == 7'h33) || (instr_i[6:0] == 7'h23) || (instr_i[6:0] == 7'h63);
        hz = instr_valid_i && m_ex.mr && (m_ex.rd != 5'd0) &&
             ((m_ex.rd == instr_i[19:15]) || (rs2 && (m_ex.rd == instr_i[24:20])));
        stall = 1'b0;
        n_ex = m_ex;
        n_mem = m_ex;
        n_wb = m_mem;
        n_ls = m_ls;
        n_md = m_md;
        if (m_md > 0) begin
            stall = 1'b1;
            n_mem = bubble();
            n_md = m_md - 1;
        end else if (flush_i) begin
            n_ex = bubble();
            n_ls = 0;
        end else if (m_ls > 0 || hz) begin
            stall = 1'b1;
            n_ex = bubble();
            n_ls = (m_ls > 0) ? m_ls - 1 : LB - 1;
        end else begin
            n_ex = d;
            if (d.muldiv) n_md = MC - 1;
        end
        n_ill = ill;
        chk("STALLSIG", STALLSIG, stall);
        chk("ex_ALUSRC", ex_ALUSRC, m_ex.alusrc);
        chk("ex_IMMTOREG", ex_IMMTOREG, m_ex.immtoreg);
        chk("ex_MULDIV", ex_MULDIV, m_ex.muldiv);
        chk("ex_ALUOP", ex_ALUOP, m_ex.aluop);
        chk("ex_BRANCH", ex_BRANCH, m_ex.branch);
        chk("ex_rd", ex_rd, m_ex.rd);
        chk("mem_MEMWRITE", mem_MEMWRITE, m_mem.mw);
        chk("mem_MEMREAD", mem_MEMREAD, m_mem.mr);
        chk("mem_rd", mem_rd, m_mem.rd);
        chk("wb_REGWRITE", wb_REGWRITE, m_wb.rw);
        chk("wb_REGWRITESEL", wb_REGWRITESEL, m_wb.wsel);
        chk("wb_rd", wb_rd, m_wb.rd);
        chk("illegal_o", illegal_o, m_ill);
    end

    task automatic put(input logic [31:0] ins, input logic v, input logic f);
        instr_i = ins;
        instr_valid_i = v;
        flush_i = f;
        @(negedge clk);
        if (STALLSIG === 1'b1) stall_seen++;
        if (ex_MULDIV === 1'b1) md_seen++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_instr();
        int k;
        logic [6:0] op, f7;
        k = $urandom_range(0, 13);
        f7 = ($urandom_range(0, 3) == 0) ? 7'h20 : 7'h00;
        if (k == 11) begin
            op = 7'h33;
            f7 = 7'h01;
        end else if (k >= 12) begin
            op = 7'h03;
        end else begin
            op = rnd_ops[k];
        end
        return {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                5'($urandom_range(0, 3)), op};
    endfunction

    initial begin
        model_reset();
        put(32'd0, 1'b0, 1'b0);
        chk("rst_stall", STALLSIG, 0);
        chk("rst_ex_branch", ex_BRANCH, 1);
        chk("rst_wb_regwrite", wb_REGWRITE, 0);
        tick();
        rst_n = 1'b1;

        // add x1,x2,x3 through the pipe
        stall_seen = 0;
        put(ADD123, 1'b1, 1'b0); tick();
        put(32'd0, 1'b0, 1'b0);
        chk("add_ex_aluop", ex_ALUOP, 2);
        chk("add_ex_rd", ex_rd, 1);
        tick();
        put(32'd0, 1'b0, 1'b0); chk("add_mem_rd", mem_rd, 1); tick();
        put(32'd0, 1'b0, 1'b0);
        chk("add_wb_regwrite", wb_REGWRITE, 1);
        chk("add_wb_rd", wb_rd, 1);
        tick();
        chk("add_no_stall", stall_seen, 0);

        // load-use with two bubbles
        stall_seen = 0;
        put(LW5, 1'b1, 1'b0); tick();
        put(ADD652, 1'b1, 1'b0); chk("lu_stall1", STALLSIG, 1); chk("lu_ex_lw", ex_rd, 5); tick();
        put(ADD652, 1'b1, 1'b0); chk("lu_stall2", STALLSIG, 1); chk("lu_bubble1", ex_rd, 0);
        chk("lu_mem_lw", mem_MEMREAD, 1); tick();
        put(ADD652, 1'b1, 1'b0); chk("lu_release", STALLSIG, 0); chk("lu_bubble2", ex_ALUOP, 0); tick();
        put(32'd0, 1'b0, 1'b0); chk("lu_add_ex", ex_rd, 6); chk("lu_add_aluop", ex_ALUOP, 2); tick();
        chk("lu_stall_count", stall_seen, 2);

        // destination x0 never creates a hazard
        stall_seen = 0;
        put(LW0, 1'b1, 1'b0); tick();
        put(ADD602, 1'b1, 1'b0); tick();
        put(32'd0, 1'b0, 1'b0); chk("x0_add_ex", ex_rd, 6); tick();
        chk("x0_no_stall", stall_seen, 0);

        // flush beats a load-use hazard
        put(LW5, 1'b1, 1'b0); tick();
        put(ADD652, 1'b1, 1'b1); chk("fl_stall", STALLSIG, 0); tick();
        put(ADD652, 1'b1, 1'b0);
        chk("fl_ex_bubble_rd", ex_rd, 0);
        chk("fl_ex_bubble_branch", ex_BRANCH, 1);
        chk("fl_run", STALLSIG, 0);
        tick();

        // M-extension op
        stall_seen = 0;
        md_seen = 0;
        put(MUL712, 1'b1, 1'b0); tick();
        put(32'd0, 1'b0, 1'b0);
`ifdef CTRL_MEXT_EN
        chk("mul_legal", illegal_o, 0);
`else
        chk("mul_illegal", illegal_o, 1);
        chk("mul_bubble", ex_rd, 0);
`endif
        tick();
        for (int i = 0; i < 5; i++) begin
            put(32'd0, 1'b0, 1'b0); tick();
        end
`ifdef CTRL_MEXT_EN
        chk("mul_muldiv_cycles", md_seen, 4);
        chk("mul_stall_cycles", stall_seen, 3);
`else
        chk("mul_muldiv_cycles", md_seen, 0);
        chk("mul_stall_cycles", stall_seen, 0);
`endif

        // reset in the middle of a load stall
        put(LW5, 1'b1, 1'b0); tick();
        put(ADD652, 1'b1, 1'b0); tick();
        instr_i = ADD652;
        #1 rst_n = 1'b0;
        #1;
        chk("mr_stall", STALLSIG, 0);
        chk("mr_ex_rd", ex_rd, 0);
        chk("mr_ex_branch", ex_BRANCH, 1);
        chk("mr_mem_memread", mem_MEMREAD, 0);
        put(ADD652, 1'b1, 1'b0); tick();
        rst_n = 1'b1;
        put(ADD652, 1'b1, 1'b0); chk("mr_no_residual", STALLSIG, 0); tick();
        put(32'd0, 1'b0, 1'b0); chk("mr_decode", ex_rd, 6); tick();

        // randomized traffic, model checks every cycle
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                rst_n = 1'b0;
                put(rnd_instr(), 1'b1, 1'b0);
                tick();
                rst_n = 1'b1;
            end else begin
                put(rnd_instr(), ($urandom_range(0, 9) != 0), ($urandom_range(0, 7) == 0));
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl_unit.md
PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

Interface
REQ-001 Parameter LOAD_BUBBLES, default 1, sets the bubbles inserted on a load-use hazard (legal 1..3).
REQ-002 Parameter MULDIV_CYCLES, default 4, sets the EX occupancy of an M-extension op (legal 2..32).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- instr_i  in  32  ID-stage instruction.
- instr_valid_i  in  1  instr_i is a real instruction, not a bubble.
- flush_i  in  1  branch/jump taken in EX; kill ID.
- STALLSIG  out  1  hold PC and IF/ID.
- ex_ALUSRC, ex_IMMTOREG, ex_MULDIV  out  1 each  EX controls.
- ex_ALUOP, ex_BRANCH  out  2 each  EX controls.
- mem_MEMWRITE, mem_MEMREAD  out  1 each  MEM controls.
- wb_REGWRITE  out  1  WB control.
- wb_REGWRITESEL  out  2  WB control.
- ex_rd, mem_rd, wb_rd  out  5 each  destination register per stage.
- illegal_o  out  1  registered; ID opcode not decodable.

Function
REQ-005 Decode SHALL be combinational on instr_i[6:0]; every don't-care field SHALL drive 0 (never x). Fields are {ALUSRC, IMMTOREG, ALUOP, BRANCH, REGWRITESEL, MEMWRITE, MEMREAD, REGWRITE}:
- 0110011: {0, 0, 10, 01, 00, 0, 0, 1}
- 0010011: {1, 0, 10, 01, 00, 0, 0, 1}
- 0000011: {1, 0, 00, 01, 01, 0, 1, 1}
- 1100111: {1, 0, 11, 10, 10, 0, 0, 1}
- 0100011: {1, 0, 00, 01, 00, 1, 0, 0}
- 1100011: {0, 0, 01, 11, 00, 0, 0, 0}
- 0110111: {0, 1, 00, 01, 00, 0, 0, 1}
- 0010111: {0, 0, 11, 11, 11, 0, 0, 1}
- 1101111: {0, 0, 11, 11, 10, 0, 0, 1}
REQ-006 Any other opcode, or instr_valid_i=0, SHALL decode as a bubble: all fields 0, BRANCH=01. illegal_o SHALL be set only for an unlisted opcode with instr_valid_i=1.
REQ-007 Decoded fields SHALL advance ID->EX->MEM->WB one stage per clock. Latency SHALL be 1 cycle to ex_*, 2 to mem_*, 3 to wb_*.
REQ-008 Load-use hazard: EX holds MEMREAD=1, ex_rd!=0, and ex_rd equals instr_i[19:15] or instr_i[24:20] (rs2 compared for R, S and B types only). On this condition STALLSIG SHALL assert combinationally in that cycle.
REQ-009 FSM states are RUN, LSTALL, MDBUSY.
- RUN->LSTALL on a hazard; STALLSIG stays 1 for LOAD_BUBBLES cycles.
- The EX register SHALL receive a bubble each stalled cycle.
- LSTALL->RUN after the count expires.
REQ-010 RUN->MDBUSY when an M-op enters EX. ex_* SHALL hold and STALLSIG=1 for MULDIV_CYCLES-1 further cycles; MEM receives bubbles meanwhile; then MDBUSY->RUN.
REQ-011 flush_i SHALL take priority over stall. The instruction in ID becomes a bubble in EX, the LSTALL counter clears, and the FSM returns to RUN. flush_i during MDBUSY SHALL be ignored, because the M-op is older than the branch.
REQ-012 MEM and WB registers SHALL always advance, except as stated in REQ-010.

Reset
REQ-013 While rst_n=0:
- all stage registers hold bubbles;
- all outputs are 0 except ex_BRANCH=01;
- STALLSIG=0, the FSM is in RUN and the counters are 0.
REQ-014 Reset assertion mid-stall or mid-MDBUSY SHALL abort the operation immediately. The first cycle after deassertion SHALL decode normally.

Configuration
REQ-015 With CTRL_MEXT_EN defined: opcode 0110011 with funct7=0000001 SHALL set MULDIV=1, ALUOP=10, REGWRITE=1, and follow REQ-010.
REQ-016 Without CTRL_MEXT_EN: that encoding SHALL decode as a bubble, set illegal_o, and never enter MDBUSY. ex_MULDIV SHALL be tied to 0.

Verification
REQ-017 Reset check: reset released, add x1,x2,x3 -> ex_ALUOP=10 after 1 clk; wb_REGWRITE=1, wb_rd=1 after 3 clk; STALLSIG=0 throughout.
REQ-018 Load-use: lw x5,0(x1) then add x6,x5,x2 with LOAD_BUBBLES=2 -> STALLSIG=1 for exactly 2 cycles; two bubbles follow the lw in EX.
REQ-019 No false hazard: lw x0,0(x1) then add x6,x0,x2 -> STALLSIG stays 0.
REQ-020 Flush priority: flush_i=1 in the same cycle as a load-use hazard -> STALLSIG=0; next ex_* is a bubble; FSM is in RUN.
REQ-021 M-op, CTRL_MEXT_EN on: mul x7,x1,x2 with MULDIV_CYCLES=4 -> ex_MULDIV=1 for 4 cycles, STALLSIG=1 for 3. With the macro off -> illegal_o=1 and a bubble.
REQ-022 Reset mid-operation: rst_n pulsed low during LSTALL -> all outputs are at reset values within the same cycle; no residual stall.
